// File: rtl/pulse_width_monitor.sv
// rtl/pulse_width_monitor.sv - measures synchronized high-pulse widths and hands them out with valid/ready
module pulse_width_monitor #(
    parameter int CNT_W = 8,
    parameter int MIN_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic [CNT_W-1:0] width,
    output logic             width_valid,
    input  logic             width_ready,
    output logic             sat,
    output logic             dropped
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_W);

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic             s_prev;
    logic             rise;
    logic [CNT_W-1:0] count;
    logic             sat_r;

    logic             start;
    logic             incr;
    logic             capture;
    logic             xfer;
    logic             drop_set;

    assign rise = s2 & ~s_prev;

    // Two-flop synchronizer for the asynchronous input plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s1     <= a;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; only a rising edge starts a measurement, never a held level
    always_comb begin
        state_next = state;
        start      = 1'b0;
        incr       = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        drop_set   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    start      = 1'b1;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (s2) begin
                    incr = 1'b1;
                end else if (count >= MIN_CNT) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                drop_set = rise;
                if (width_valid && width_ready) begin
                    xfer       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter, saturation tracking, result register and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            sat_r       <= 1'b0;
            width       <= '0;
            width_valid <= 1'b0;
            sat         <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            if (start) begin
                count <= CNT_ONE;
                sat_r <= 1'b0;
            end else if (incr) begin
                if (count == CNT_MAX) begin
                    sat_r <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
            end
            if (capture) begin
                width       <= count;
                sat         <= sat_r;
                width_valid <= 1'b1;
            end else if (xfer) begin
                width_valid <= 1'b0;
            end
            if (drop_set) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_monitor.sv
// tb/tb_pulse_width_monitor.sv - scoreboard bench for pulse_width_monitor
module tb_pulse_width_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       width_ready;
    logic [7:0] width;
    logic       width_valid;
    logic       sat;
    logic       dropped;

    logic       a2;
    logic       ready2;
    logic [3:0] width2;
    logic       valid2;
    logic       sat2;
    logic       dropped2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] w;
        logic       s;
    } res_t;

    res_t exp_q[$];

    logic [7:0] obs_w [64];
    logic       obs_s [64];
    int         obs_cnt = 0;
    int         valid_cycles = 0;
    int         rd_ptr = 0;

    always #5 clk = ~clk;

    pulse_width_monitor #(.CNT_W(8), .MIN_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .width       (width),
        .width_valid (width_valid),
        .width_ready (width_ready),
        .sat         (sat),
        .dropped     (dropped)
    );

    pulse_width_monitor #(.CNT_W(4), .MIN_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .a           (a2),
        .width       (width2),
        .width_valid (valid2),
        .width_ready (ready2),
        .sat         (sat2),
        .dropped     (dropped2)
    );

    // Capture every accepted result and count valid cycles
    always @(negedge clk) begin
        if (!rst && width_valid) begin
            valid_cycles <= valid_cycles + 1;
            if (width_ready) begin
                obs_w[obs_cnt[5:0]] <= width;
                obs_s[obs_cnt[5:0]] <= sat;
                obs_cnt <= obs_cnt + 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        a = 1'b1;
        cyc(hi);
        a = 1'b0;
        cyc(lo);
    endtask

    task automatic drain_scoreboard(input string tag);
        res_t e;
        int   waited;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            waited = 0;
            while (obs_cnt <= rd_ptr && waited < 60) begin
                cyc(1);
                waited++;
            end
            checks++;
            if (obs_cnt <= rd_ptr) begin
                errors++;
                $display("FAIL %s timeout: got no result, expected width=%0d sat=%0d", tag, e.w, e.s);
            end else begin
                if (obs_w[rd_ptr[5:0]] !== e.w || obs_s[rd_ptr[5:0]] !== e.s) begin
                    errors++;
                    $display("FAIL %s result: got width=%0d sat=%0d, expected width=%0d sat=%0d",
                             tag, obs_w[rd_ptr[5:0]], obs_s[rd_ptr[5:0]], e.w, e.s);
                end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a = 1'b0;
        a2 = 1'b0;
        width_ready = 1'b0;
        ready2 = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        checks++;
        if ({width, width_valid, sat, dropped} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got width=%0d valid=%b sat=%b dropped=%b, expected all 0",
                     width, width_valid, sat, dropped);
        end
        checks++;
        if ({width2, valid2, sat2, dropped2} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs_sat: got width=%0d valid=%b sat=%b dropped=%b, expected all 0",
                     width2, valid2, sat2, dropped2);
        end
    endtask

    task automatic test_basic();
        int vc0;
        width_ready = 1'b1;
        exp_q.push_back('{w: 8'd5, s: 1'b0});
        vc0 = valid_cycles;
        a = 1'b1;
        cyc(5);
        a = 1'b0;
        cyc(2);
        checks++;
        if (width_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: got valid=%b one edge too soon, expected 0", width_valid);
        end
        cyc(1);
        checks++;
        if (width_valid !== 1'b1 || width !== 8'd5 || sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: got valid=%b width=%0d sat=%b, expected 1 5 0",
                     width_valid, width, sat);
        end
        drain_scoreboard("basic");
        cyc(3);
        checks++;
        if (valid_cycles - vc0 !== 1) begin
            errors++;
            $display("FAIL basic_valid_len: got %0d valid cycles, expected 1", valid_cycles - vc0);
        end
    endtask

    task automatic test_glitch();
        int oc0;
        width_ready = 1'b1;
        oc0 = obs_cnt;
        pulse(1, 8);
        checks++;
        if (obs_cnt !== oc0 || width_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: got %0d results valid=%b, expected 0 results valid=0",
                     obs_cnt - oc0, width_valid);
        end
        exp_q.push_back('{w: 8'd3, s: 1'b0});
        pulse(3, 2);
        drain_scoreboard("glitch_then_3");
    endtask

    task automatic test_saturation();
        int waited;
        ready2 = 1'b0;
        a2 = 1'b1;
        cyc(20);
        a2 = 1'b0;
        waited = 0;
        while (!valid2 && waited < 10) begin
            cyc(1);
            waited++;
        end
        checks++;
        if (valid2 !== 1'b1 || width2 !== 4'd15 || sat2 !== 1'b1) begin
            errors++;
            $display("FAIL saturation: got valid=%b width=%0d sat=%b, expected 1 15 1",
                     valid2, width2, sat2);
        end
        ready2 = 1'b1;
        cyc(1);
        ready2 = 1'b0;
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("FAIL saturation_xfer: got valid=%b after transfer, expected 0", valid2);
        end
    endtask

    task automatic test_backpressure();
        int  oc0;
        logic unstable;
        width_ready = 1'b0;
        oc0 = obs_cnt;
        exp_q.push_back('{w: 8'd4, s: 1'b0});
        pulse(4, 3);
        unstable = 1'b0;
        a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) a = 1'b0;
            cyc(1);
            if (width_valid !== 1'b1 || width !== 8'd4 || sat !== 1'b0) unstable = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL hold_stable: result changed while stalled, now valid=%b width=%0d, expected 1 4",
                     width_valid, width);
        end
        checks++;
        if (dropped !== 1'b1) begin
            errors++;
            $display("FAIL dropped_set: got dropped=%b, expected 1", dropped);
        end
        width_ready = 1'b1;
        drain_scoreboard("backpressure");
        cyc(15);
        checks++;
        if (obs_cnt - oc0 !== 1 || dropped !== 1'b1) begin
            errors++;
            $display("FAIL drop_no_result: got %0d results dropped=%b, expected 1 result dropped=1",
                     obs_cnt - oc0, dropped);
        end
    endtask

    task automatic test_reset_mid();
        width_ready = 1'b0;
        a = 1'b1;
        cyc(5);
        rst = 1'b1;
        a = 1'b0;
        cyc(1);
        rst = 1'b0;
        checks++;
        if ({width, width_valid, sat, dropped} !== 11'd0) begin
            errors++;
            $display("FAIL reset_measure: got width=%0d valid=%b sat=%b dropped=%b, expected all 0",
                     width, width_valid, sat, dropped);
        end
        cyc(4);
        pulse(3, 5);
        checks++;
        if (width_valid !== 1'b1 || width !== 8'd3) begin
            errors++;
            $display("FAIL pre_hold: got valid=%b width=%0d, expected 1 3", width_valid, width);
        end
        rst = 1'b1;
        a = 1'b1;
        cyc(1);
        checks++;
        if ({width, width_valid, sat, dropped} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got width=%0d valid=%b sat=%b dropped=%b, expected all 0",
                     width, width_valid, sat, dropped);
        end
        cyc(1);
        rst = 1'b0;
        width_ready = 1'b1;
        exp_q.push_back('{w: 8'd4, s: 1'b0});
        cyc(4);
        a = 1'b0;
        drain_scoreboard("after_reset");
    endtask

    task automatic test_back_to_back();
        width_ready = 1'b1;
        exp_q.push_back('{w: 8'd3, s: 1'b0});
        exp_q.push_back('{w: 8'd7, s: 1'b0});
        exp_q.push_back('{w: 8'd2, s: 1'b0});
        pulse(3, 4);
        pulse(7, 4);
        pulse(2, 4);
        drain_scoreboard("back_to_back");
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL b2b_dropped: got dropped=%b, expected 0", dropped);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_width_monitor.md
PULSE_WIDTH_MONITOR -- requirements
Module: pulse_width_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the pulse-width count.
REQ-002 SHALL have parameter MIN_W, default 2: minimum accepted pulse width in cycles; shorter pulses are rejected as glitches.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port a, input, 1: asynchronous monitored signal (the stimulus line a driven by benches).
REQ-006 SHALL have port width, output, CNT_W: measured high-pulse width in clk cycles.
REQ-007 SHALL have port width_valid, output, 1: width holds a result.
REQ-008 SHALL have port width_ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port sat, output, 1: the current result saturated; valid only with width_valid.
REQ-010 SHALL have port dropped, output, 1: sticky flag; a pulse started while a result was pending.

Function
REQ-011 SHALL pass a through a 2-flop synchronizer (s1, s2) and register s2 as s_prev; rise = s2 & ~s_prev.
REQ-012 SHALL implement FSM states IDLE, MEASURE, HOLD.
REQ-013 IDLE: on rise -> MEASURE, count <= 1; otherwise stay. A level already high on entry to IDLE without rise SHALL NOT start a measurement.
REQ-014 MEASURE, s2=1: count <= count+1, saturating at 2^CNT_W-1; sat_r set on any attempted increment past the maximum.
REQ-015 MEASURE, s2=0, count >= MIN_W: -> HOLD; width <= count, sat <= sat_r, width_valid <= 1.
REQ-016 MEASURE, s2=0, count < MIN_W: -> IDLE with no output and no flag change (glitch rejected).
REQ-017 HOLD: width, sat and width_valid SHALL stay stable until width_valid & width_ready at a clock edge; on that edge -> IDLE, width_valid <= 0.
REQ-018 Any rise seen in HOLD, including on the transfer edge, SHALL set dropped and SHALL NOT be measured.
REQ-019 dropped SHALL stay set until reset.
REQ-020 Latency: if a is sampled high on edges t..t+N-1 and low at t+N, width_valid SHALL be 1 after edge t+N+2, with width = N (N >= MIN_W, no saturation).
REQ-021 width_ready while width_valid=0 SHALL have no effect.
REQ-022 count, sat_r and width SHALL be exactly CNT_W / 1 / CNT_W bits; no wrap-around to 0 is permitted.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, s1=s2=s_prev=0, count=0, sat_r=0, width=0, width_valid=0, sat=0, dropped=0, from any state, including mid-MEASURE and HOLD.
REQ-024 After reset release with a held high, the first s2=1 SHALL count as a rise; the measured width SHALL count from that point.

Verification
REQ-025 Basic: a high 5 cycles, width_ready=1 -> width_valid for exactly 1 cycle, 2 edges after a falls, width=5, sat=0.
REQ-026 Glitch: a high 1 cycle (MIN_W=2) -> no width_valid; then a high 3 cycles -> width=3.
REQ-027 Saturation: CNT_W=4, a high 20 cycles -> width=15, sat=1.
REQ-028 Backpressure/drop: width_ready=0, a high 4 cycles, low 3, high 6 -> width=4 held stable, dropped=1; then ready=1 -> one transfer, and no result for the 6-cycle pulse.
REQ-029 Reset mid-operation: rst asserted during MEASURE (count=3) and again in HOLD -> all outputs 0 next cycle; the next 4-cycle pulse gives width=4.
REQ-030 Back-to-back: pulses of 3, 7, 2 cycles separated by 4 low cycles, ready=1 -> results 3, 7, 2 in order, dropped=0.
